// File: rtl/shared_wide_adder_seq_if.sv
// Request/result bundle for shared_wide_adder_seq: two operand requesters and one result port.
interface shared_wide_adder_seq_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;
    logic             res_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id, res_ovf
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id, res_ovf
    );
endinterface

// File: rtl/shared_wide_adder_seq.sv
// Round-robin sequencer time-sharing one 8-bit adder slice between two requesters, LSB first.
// Define OVERFLOW_DETECT_EN to capture signed overflow of the top slice into res_ovf.
module shared_wide_adder_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    shared_wide_adder_seq_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / 8;
    localparam int unsigned IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q;
    logic             last_grant_q;
    logic             id_q;
    logic             carry_q;
    logic             cout_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;

    logic       grant;
    logic       accept;
    logic [7:0] slice_a;
    logic [7:0] slice_b;
    logic [7:0] slice_s;
    logic       slice_c;

    // With both requesters valid, the one that did not win last time goes next.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign bus.req0_ready = (state_q == StIdle) && bus.req0_valid && !grant;
    assign bus.req1_ready = (state_q == StIdle) && bus.req1_valid && grant;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign slice_a = a_q[{idx_q, 3'b000} +: 8];
    assign slice_b = b_q[{idx_q, 3'b000} +: 8];
    assign {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {8'd0, carry_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q          <= grant ? bus.req1_a : bus.req0_a;
                        b_q          <= grant ? bus.req1_b : bus.req0_b;
                        carry_q      <= grant ? bus.req1_cin : bus.req0_cin;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        idx_q        <= '0;
                        state_q      <= StRun;
                    end
                end
                StRun: begin
                    sum_q[{idx_q, 3'b000} +: 8] <= slice_s;
                    carry_q <= slice_c;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_c;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.res_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.res_valid = (state_q == StDone);
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
    assign bus.res_id    = id_q;

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q;

    // Carry into bit 7 of the top byte is recovered from the sum bit and its two operand bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == StRun && idx_q == LAST_IDX) begin
            ovf_q <= slice_c ^ (slice_a[7] ^ slice_b[7] ^ slice_s[7]);
        end
    end

    assign bus.res_ovf = ovf_q;
`else
    assign bus.res_ovf = 1'b0;
`endif

endmodule
